// File: rtl/seg_display_scan_driver_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver.
// Contents:
//   ScanState  - two-phase slot state (blank gap, then digit lit)
//   SEG_OFF    - active-high "all segments dark" pattern
//   SEG_HEX    - active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F
//   hexToSeg   - nibble -> active-high segment pattern lookup
package seg_display_scan_driver_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } ScanState;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Element [n] holds the glyph for hex value n; the list runs from F down to 0.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hexToSeg(input logic [3:0] nibble);
    return SEG_HEX[nibble];
  endfunction

endpackage

// File: rtl/seg_display_scan_driver_if.sv
// Bus between the display data producer (master) and the scan driver (slave).
// Signals:
//   load        - 1-cycle strobe capturing digits_in/dp_in/digit_en
//   digits_in   - hex nibble per digit, digit 0 in bits [3:0]
//   dp_in       - decimal point per digit (1 = lit)
//   digit_en    - 1 = digit shown, 0 = slot kept dark
//   update_pend - captured data waiting for the next frame boundary
//   frame_done  - pulse on the last output cycle of the final digit
//   anode_out   - digit select, one-hot when active
//   seg_out     - segments {g,f,e,d,c,b,a}
//   dp_out      - decimal point
interface seg_display_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);

  logic                      load;
  logic [4*NUM_DIGITS-1:0]   digits_in;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic [NUM_DIGITS-1:0]     digit_en;
  logic                      update_pend;
  logic                      frame_done;
  logic [NUM_DIGITS-1:0]     anode_out;
  logic [6:0]                seg_out;
  logic                      dp_out;

  modport master (
    output load, digits_in, dp_in, digit_en,
    input  update_pend, frame_done, anode_out, seg_out, dp_out
  );

  modport slave (
    input  load, digits_in, dp_in, digit_en,
    output update_pend, frame_done, anode_out, seg_out, dp_out
  );

endinterface

// File: rtl/seg_display_scan_driver_hex_to_seg7.sv
// Combinational hex nibble to 7-segment decoder, reusable by any display user.
// Ports:
//   nibble_i - hex value 0..F
//   seg_o    - active-high {g,f,e,d,c,b,a} pattern
module hex_to_seg7
  import seg_display_scan_driver_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Pure table lookup; polarity is left to the caller.
  always_comb begin
    seg_o = hexToSeg(nibble_i);
  end

endmodule

// File: rtl/seg_display_scan_driver.sv
// Multiplexed 7-segment scan driver. Each digit slot starts with a blanking gap
// (all anodes off) to avoid ghosting, then lights the digit. New display data is
// held in a pending register and copied into the shadow (displayed) register only
// at a frame boundary, so a frame never mixes old and new values.
// Ports:
//   clock - system clock
//   reset - synchronous, active-high
//   bus   - slave side of seg_display_scan_driver_if (load/data in, display out)
module seg_display_scan_driver
  import seg_display_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input logic                        clock,
  input logic                        reset,
  seg_display_scan_driver_if.slave   bus
);

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  // XOR masks that turn active-high values into the physical output polarity.
  localparam logic [NUM_DIGITS-1:0] POL_ANODE = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]            POL_SEG   = {7{ACTIVE_LOW}};

  ScanState                    stateQ, stateD;
  logic [CW-1:0]               slotCntQ, slotCntD;
  logic [IW-1:0]               digitIdxQ, digitIdxD;
  logic [NUM_DIGITS-1:0][3:0]  pendDigitsQ, pendDigitsD;
  logic [NUM_DIGITS-1:0]       pendDpQ, pendDpD;
  logic [NUM_DIGITS-1:0]       pendEnQ, pendEnD;
  logic                        pendValidQ, pendValidD;
  logic [NUM_DIGITS-1:0][3:0]  shadowDigitsQ, shadowDigitsD;
  logic [NUM_DIGITS-1:0]       shadowDpQ, shadowDpD;
  logic [NUM_DIGITS-1:0]       shadowEnQ, shadowEnD;
  logic [NUM_DIGITS-1:0]       anodeQ, anodeD;
  logic [6:0]                  segQ, segD;
  logic                        dpQ, dpD;
  logic                        frameDoneQ, frameDoneD;
  logic                        frameBoundary;
  logic [3:0]                  curNibble;
  logic [6:0]                  curSeg;

  assign curNibble = shadowDigitsQ[digitIdxQ];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble_i (curNibble),
    .seg_o    (curSeg)
  );

  // Next-state logic: scan FSM and counters, the pending/shadow handoff, and the
  // next values of the registered outputs (computed from the current state so the
  // pins lag the internal scan position by exactly one cycle).
  always_comb begin
    stateD        = stateQ;
    slotCntD      = slotCntQ + 1'b1;
    digitIdxD     = digitIdxQ;
    frameBoundary = 1'b0;
    pendDigitsD   = pendDigitsQ;
    pendDpD       = pendDpQ;
    pendEnD       = pendEnQ;
    pendValidD    = pendValidQ;
    shadowDigitsD = shadowDigitsQ;
    shadowDpD     = shadowDpQ;
    shadowEnD     = shadowEnQ;
    anodeD        = POL_ANODE;
    segD          = SEG_OFF ^ POL_SEG;
    dpD           = ACTIVE_LOW;
    frameDoneD    = 1'b0;

    // The slot counter free-runs through both phases; only the end of the ON
    // phase resets it and advances the digit.
    case (stateQ)
      ST_BLANK: begin
        if (slotCntQ == BLANK_LAST) begin
          stateD = ST_ON;
        end
      end
      ST_ON: begin
        if (slotCntQ == SLOT_LAST) begin
          stateD        = ST_BLANK;
          slotCntD      = '0;
          frameBoundary = (digitIdxQ == IDX_LAST);
          digitIdxD     = (digitIdxQ == IDX_LAST) ? '0 : digitIdxQ + 1'b1;
        end
      end
      default: begin
        stateD = ST_BLANK;
      end
    endcase

    // A load on the boundary cycle goes straight to the shadow and supersedes
    // anything pending; otherwise pending data moves over at the boundary.
    if (frameBoundary) begin
      if (bus.load) begin
        shadowDigitsD = bus.digits_in;
        shadowDpD     = bus.dp_in;
        shadowEnD     = bus.digit_en;
      end else if (pendValidQ) begin
        shadowDigitsD = pendDigitsQ;
        shadowDpD     = pendDpQ;
        shadowEnD     = pendEnQ;
      end
      pendValidD = 1'b0;
    end else if (bus.load) begin
      pendDigitsD = bus.digits_in;
      pendDpD     = bus.dp_in;
      pendEnD     = bus.digit_en;
      pendValidD  = 1'b1;
    end

    frameDoneD = frameBoundary;

    // Disabled digits keep anode, segments and dp dark for the whole slot.
    if ((stateQ == ST_ON) && shadowEnQ[digitIdxQ]) begin
      anodeD = (NUM_DIGITS'(1) << digitIdxQ) ^ POL_ANODE;
      segD   = curSeg ^ POL_SEG;
      dpD    = shadowDpQ[digitIdxQ] ^ ACTIVE_LOW;
    end
  end

  // State and output registers. Reset drops any pending update and clears the
  // shadow, so the scan restarts at digit 0 with nothing lit.
  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ        <= ST_BLANK;
      slotCntQ      <= '0;
      digitIdxQ     <= '0;
      pendDigitsQ   <= '0;
      pendDpQ       <= '0;
      pendEnQ       <= '0;
      pendValidQ    <= 1'b0;
      shadowDigitsQ <= '0;
      shadowDpQ     <= '0;
      shadowEnQ     <= '0;
      anodeQ        <= POL_ANODE;
      segQ          <= SEG_OFF ^ POL_SEG;
      dpQ           <= ACTIVE_LOW;
      frameDoneQ    <= 1'b0;
    end else begin
      stateQ        <= stateD;
      slotCntQ      <= slotCntD;
      digitIdxQ     <= digitIdxD;
      pendDigitsQ   <= pendDigitsD;
      pendDpQ       <= pendDpD;
      pendEnQ       <= pendEnD;
      pendValidQ    <= pendValidD;
      shadowDigitsQ <= shadowDigitsD;
      shadowDpQ     <= shadowDpD;
      shadowEnQ     <= shadowEnD;
      anodeQ        <= anodeD;
      segQ          <= segD;
      dpQ           <= dpD;
      frameDoneQ    <= frameDoneD;
    end
  end

  assign bus.anode_out   = anodeQ;
  assign bus.seg_out     = segQ;
  assign bus.dp_out      = dpQ;
  assign bus.update_pend = pendValidQ;
  assign bus.frame_done  = frameDoneQ;

endmodule
